// File: rtl/fp_pack_if.sv
// Handshake bus for the FP pack/round stage.
//   in_*  : unpacked operand from the arithmetic unit (valid/ready)
//   out_* : packed IEEE-754 result plus exception flags (valid/ready)
// master = operand producer / result consumer, slave = fp_pack.
interface fp_pack_if #(
  parameter int unsigned n_exp = 8,
  parameter int unsigned n_sig = 23
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_sign;
  logic signed [n_exp+1:0]   in_exp;
  logic [n_sig+3:0]          in_sig;
  logic [5:0]                in_flags;
  logic                      out_valid;
  logic                      out_ready;
  logic [n_exp+n_sig:0]      f;
  logic                      overflow;
  logic                      underflow;
  logic                      inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_sig, in_flags, out_ready,
    input  in_ready, out_valid, f, overflow, underflow, inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_sig, in_flags, out_ready,
    output in_ready, out_valid, f, overflow, underflow, inexact
  );
endinterface

// File: rtl/fp_pack.sv
// Pack and round stage of the FPU: normalises/denormalises an unpacked
// result one bit per cycle, rounds to nearest-even and emits the IEEE-754
// encoding with overflow/underflow/inexact flags. One operation in flight.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - fp_pack_if.slave: operand in (in_valid/in_ready, in_sign,
//          in_exp, in_sig, in_flags), result out (out_valid/out_ready, f,
//          overflow, underflow, inexact)
// in_flags bit order: [5] snan, [4] qnan, [3] inf, [2] zero, [1] subnorm,
// [0] norm.
module fp_pack #(
  parameter int unsigned n_exp = 8,
  parameter int unsigned n_sig = 23
) (
  input  logic       clk,
  input  logic       rst,
  fp_pack_if.slave   bus
);

  localparam int unsigned sw   = n_sig + 4;          // significand register
  localparam int unsigned fw   = n_exp + n_sig + 1;  // packed result
  // One spare bit above the input exponent width so the carry and round
  // increments at the very top of the input range cannot wrap.
  localparam int unsigned ew   = n_exp + 3;
  localparam int          bias = (1 << (n_exp - 1)) - 1;

  localparam logic signed [ew-1:0] emin_v  = ew'(1 - bias);
  localparam logic signed [ew-1:0] emax_v  = ew'(bias);
  localparam logic signed [ew-1:0] bias_v  = ew'(bias);
  localparam logic signed [ew-1:0] exp_one = ew'(1);

  localparam int unsigned fl_snan = 5;
  localparam int unsigned fl_qnan = 4;
  localparam int unsigned fl_inf  = 3;
  localparam int unsigned fl_zero = 2;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t                 state, state_n;
  logic                   sign_q, sign_n;
  logic signed [ew-1:0]   exp_q, exp_n;
  logic [sw-1:0]          sig_q, sig_n;
  logic [3:0]             cls_q, cls_n;     // snan, qnan, inf, zero
  logic [fw-1:0]          f_q, f_n;
  logic                   ovf_q, ovf_n;
  logic                   unf_q, unf_n;
  logic                   inx_q, inx_n;
  logic                   in_ready_q;
  logic                   out_valid_q;

  // Rounding temporaries (ROUND state only)
  logic                   up;
  logic [n_sig+1:0]       m;
  logic signed [ew-1:0]   exp_r;
  logic                   inx_r;

  // subnorm/norm class bits are informational; the datapath re-derives them
  logic                   unused_cls;
  assign unused_cls = ^bus.in_flags[1:0];

  // Next-state, datapath and result computation
  always_comb begin
    state_n = state;
    sign_n  = sign_q;
    exp_n   = exp_q;
    sig_n   = sig_q;
    cls_n   = cls_q;
    f_n     = f_q;
    ovf_n   = ovf_q;
    unf_n   = unf_q;
    inx_n   = inx_q;
    up      = 1'b0;
    m       = '0;
    exp_r   = exp_q;
    inx_r   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_n = NORM;
          sign_n  = bus.in_sign;
          exp_n   = {{(ew-n_exp-2){bus.in_exp[n_exp+1]}}, bus.in_exp};
          sig_n   = bus.in_sig;
          cls_n   = {bus.in_flags[fl_snan], bus.in_flags[fl_qnan],
                     bus.in_flags[fl_inf], bus.in_flags[fl_zero]};
        end
      end

      NORM: begin
        if (cls_q[3] | cls_q[2]) begin
          // Any NaN collapses to the canonical quiet NaN
          f_n     = {1'b0, {n_exp{1'b1}}, 1'b1, {(n_sig-1){1'b0}}};
          ovf_n   = 1'b0;
          unf_n   = 1'b0;
          inx_n   = 1'b0;
          state_n = DONE;
        end else if (cls_q[1]) begin
          f_n     = {sign_q, {n_exp{1'b1}}, {n_sig{1'b0}}};
          ovf_n   = 1'b0;
          unf_n   = 1'b0;
          inx_n   = 1'b0;
          state_n = DONE;
        end else if (cls_q[0] || (sig_q == '0)) begin
          f_n     = {sign_q, {(fw-1){1'b0}}};
          ovf_n   = 1'b0;
          unf_n   = 1'b0;
          inx_n   = 1'b0;
          state_n = DONE;
        end else if (sig_q[sw-1]) begin
          // Carry out: shift right, jamming the lost bit into sticky
          sig_n = {1'b0, sig_q[sw-1:2], sig_q[1] | sig_q[0]};
          exp_n = exp_q + exp_one;
        end else if (exp_q < emin_v) begin
          // Denormalise; once only sticky remains, further shifts are no-ops
          if (sig_q[sw-1:1] == '0) begin
            exp_n = emin_v;
          end else begin
            sig_n = {1'b0, sig_q[sw-1:2], sig_q[1] | sig_q[0]};
            exp_n = exp_q + exp_one;
          end
        end else if (!sig_q[sw-2] && (exp_q > emin_v)) begin
          sig_n = {sig_q[sw-2:0], 1'b0};
          exp_n = exp_q - exp_one;
        end else begin
          state_n = ROUND;
        end
      end

      ROUND: begin
        // Round to nearest, ties to even: lsb=sig[2], guard=sig[1], sticky=sig[0]
        up    = sig_q[1] & (sig_q[0] | sig_q[2]);
        inx_r = sig_q[1] | sig_q[0];
        m     = {1'b0, sig_q[sw-2:2]} + (n_sig+2)'(up);
        exp_r = exp_q;
        if (m[n_sig+1]) begin
          m     = m >> 1;
          exp_r = exp_q + exp_one;
        end
        if (exp_r > emax_v) begin
          f_n   = {sign_q, {n_exp{1'b1}}, {n_sig{1'b0}}};
          ovf_n = 1'b1;
          unf_n = 1'b0;
          inx_n = 1'b1;
        end else if (m[n_sig]) begin
          f_n   = {sign_q, n_exp'(exp_r + bias_v), m[n_sig-1:0]};
          ovf_n = 1'b0;
          unf_n = 1'b0;
          inx_n = inx_r;
        end else begin
          f_n   = {sign_q, {n_exp{1'b0}}, m[n_sig-1:0]};
          ovf_n = 1'b0;
          unf_n = inx_r;
          inx_n = inx_r;
        end
        state_n = DONE;
      end

      DONE: begin
        if (bus.out_ready) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; handshake outputs registered from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      sig_q       <= '0;
      cls_q       <= '0;
      f_q         <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_n;
      sign_q      <= sign_n;
      exp_q       <= exp_n;
      sig_q       <= sig_n;
      cls_q       <= cls_n;
      f_q         <= f_n;
      ovf_q       <= ovf_n;
      unf_q       <= unf_n;
      inx_q       <= inx_n;
      in_ready_q  <= (state_n == IDLE);
      out_valid_q <= (state_n == DONE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.f         = f_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.inexact   = inx_q;

endmodule
